// File: rtl/johnson_phase_tracker.sv
// Johnson-counter phase tracker: decodes an 8-bit Johnson code, locks onto in-sequence
// phases and counts completed cycles. Define JOHNSON_TRACKER_ONEHOT_EN to add phase_oh.
module johnson_phase_tracker #(
  parameter int unsigned LOCK_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  q_in,
  input  logic        err_clr,
  output logic [3:0]  phase,
  output logic        phase_valid,
  output logic        locked,
  output logic        err,
  output logic [7:0]  cycle_cnt,
  output logic        wrap
`ifdef JOHNSON_TRACKER_ONEHOT_EN
  ,
  output logic [15:0] phase_oh
`endif
);

  typedef enum logic [1:0] {
    S_UNLOCKED,
    S_ACQUIRE,
    S_LOCKED,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  run_q, run_d;
  logic [3:0]  prev_q, prev_d;
  logic [3:0]  phase_q, phase_d;
  logic        valid_q, valid_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wrap_q, wrap_d;

  logic [3:0]  pop;
  logic [7:0]  q_inv;
  logic        code_legal;
  logic [3:0]  code_phase;
  logic [3:0]  prev_inc;

  // Legal codes are a run of ones anchored at bit 0, or its complement (run anchored at bit 7).
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pop = pop + 4'(q_in[i]);
    end
    q_inv      = ~q_in;
    code_legal = ((q_in & (q_in + 8'd1)) == '0) || ((q_inv & (q_inv + 8'd1)) == '0);
    if ((q_in == '0) || q_in[0]) begin
      code_phase = pop;
    end else begin
      code_phase = 4'd0 - pop;
    end
  end

  assign prev_inc = prev_q + 4'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = prev_q;
    phase_d = phase_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (en) begin
      valid_d = code_legal;
      if (code_legal) begin
        phase_d = code_phase;
      end
      if (err_clr) begin
        state_d = S_UNLOCKED;
        run_d   = '0;
        err_d   = 1'b0;
      end else begin
        case (state_q)
          S_UNLOCKED: begin
            if (code_legal) begin
              state_d = S_ACQUIRE;
              run_d   = 3'd1;
              prev_d  = code_phase;
            end
          end
          S_ACQUIRE: begin
            if (!code_legal) begin
              state_d = S_UNLOCKED;
              run_d   = '0;
            end else if (code_phase == prev_inc) begin
              run_d  = run_q + 3'd1;
              prev_d = code_phase;
              if (run_d == 3'(LOCK_RUN)) begin
                state_d = S_LOCKED;
              end
            end else if (code_phase != prev_q) begin
              run_d  = 3'd1;
              prev_d = code_phase;
            end
          end
          S_LOCKED: begin
            if (code_legal && (code_phase == prev_inc)) begin
              prev_d = code_phase;
              if (prev_q == 4'd15) begin
                cnt_d  = cnt_q + 8'd1;
                wrap_d = 1'b1;
              end
            end else if (!(code_legal && (code_phase == prev_q))) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_UNLOCKED;
      run_q    <= '0;
      prev_q   <= '0;
      phase_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      prev_q   <= prev_d;
      phase_q  <= phase_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign cycle_cnt   = cnt_q;
  assign wrap        = wrap_q;

`ifdef JOHNSON_TRACKER_ONEHOT_EN
  logic [15:0] oh_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oh_q <= 16'h0001;
    end else if (en) begin
      oh_q <= code_legal ? (16'h0001 << code_phase) : '0;
    end
  end

  assign phase_oh = oh_q;
`endif

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Self-checking bench for johnson_phase_tracker: directed scenarios plus a randomized
// walk, all compared against a table-driven behavioural model.
module tb_johnson_phase_tracker;
  localparam int LR = 4;

  logic        clk = 1'b0;
  logic        rst, en, err_clr;
  logic [7:0]  q_in;
  logic [3:0]  phase;
  logic        phase_valid, locked, err, wrap;
  logic [7:0]  cycle_cnt;
  logic [15:0] obs;
`ifdef JOHNSON_TRACKER_ONEHOT_EN
  logic [15:0] phase_oh;
`endif

  johnson_phase_tracker #(.LOCK_RUN(LR)) dut (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in), .err_clr(err_clr),
    .phase(phase), .phase_valid(phase_valid), .locked(locked), .err(err),
    .cycle_cnt(cycle_cnt), .wrap(wrap)
`ifdef JOHNSON_TRACKER_ONEHOT_EN
    , .phase_oh(phase_oh)
`endif
  );

  always #5 clk = ~clk;
  assign obs = {phase, phase_valid, locked, err, cycle_cnt, wrap};

  int n_pass = 0;
  int n_total = 0;

  typedef enum {M_UNL, M_ACQ, M_LCK, M_ERR} mst_t;
  mst_t        m_st;
  int          m_run, m_prev, m_phase, m_cnt;
  bit          m_valid, m_err, m_wrap;
  bit   [15:0] m_oh;
  logic [7:0]  jcode [16];

  function automatic int code_index(input logic [7:0] q);
    for (int k = 0; k < 16; k++) if (jcode[k] == q) return k;
    return -1;
  endfunction

  function automatic logic [15:0] exp_vec();
    return {4'(m_phase), m_valid, (m_st == M_LCK), m_err, 8'(m_cnt), m_wrap};
  endfunction

  task automatic model_reset();
    m_st = M_UNL; m_run = 0; m_prev = 0; m_phase = 0; m_cnt = 0;
    m_valid = 0; m_err = 0; m_wrap = 0; m_oh = 16'h0001;
  endtask

  task automatic model_step(input logic [7:0] q, input bit e, input bit c);
    int k;
    k = code_index(q);
    m_wrap = 0;
    if (!e) return;
    if (k >= 0) begin m_phase = k; m_valid = 1; m_oh = 16'h1 << k; end
    else begin m_valid = 0; m_oh = '0; end
    if (c) begin m_st = M_UNL; m_err = 0; m_run = 0; return; end
    case (m_st)
      M_UNL: if (k >= 0) begin m_st = M_ACQ; m_run = 1; m_prev = k; end
      M_ACQ: begin
        if (k < 0) begin m_st = M_UNL; m_run = 0; end
        else if (k == (m_prev + 1) % 16) begin
          m_run++; m_prev = k;
          if (m_run == LR) m_st = M_LCK;
        end else if (k != m_prev) begin m_run = 1; m_prev = k; end
      end
      M_LCK: begin
        if (k >= 0 && k == (m_prev + 1) % 16) begin
          if (m_prev == 15) begin m_cnt = (m_cnt + 1) % 256; m_wrap = 1; end
          m_prev = k;
        end else if (!(k >= 0 && k == m_prev)) begin m_st = M_ERR; m_err = 1; end
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic [7:0] q, input bit e, input bit c);
    q_in = q; en = e; err_clr = c;
    model_step(q, e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0; en = 0; err_clr = 0; q_in = '0;
    model_reset();
    #7;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; en = 0; err_clr = 0; q_in = '0;
    model_reset();
    #3;
    n_total++;
    if (obs !== exp_vec()) $display("FAIL reset_outputs got=%h exp=%h", obs, exp_vec());
    else n_pass++;
`ifdef JOHNSON_TRACKER_ONEHOT_EN
    n_total++;
    if (phase_oh !== 16'h0001) $display("FAIL reset_onehot got=%h exp=0001", phase_oh);
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_acquire();
    for (int k = 0; k < 5; k++) begin
      drive(jcode[k], 1, 0);
      n_total++;
      if (obs !== exp_vec() || phase !== 4'(k) || locked !== (k >= LR - 1))
        $display("FAIL acquire_step%0d got=%h exp=%h", k, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int pulses, idx;
    do_reset();
    pulses = 0;
    for (int k = 0; k < 4; k++) drive(jcode[k], 1, 0);
    idx = 3;
    for (int s = 0; s < 30; s++) begin
      idx = (idx + 1) % 16;
      drive(jcode[idx], 1, 0);
      if (wrap === 1'b1) pulses++;
      n_total++;
      if (obs !== exp_vec()) $display("FAIL wrap_walk%0d got=%h exp=%h", s, obs, exp_vec());
      else n_pass++;
    end
    n_total++;
    if (cycle_cnt !== 8'd2 || pulses != 2)
      $display("FAIL wrap_count got cnt=%0d pulses=%0d exp cnt=2 pulses=2", cycle_cnt, pulses);
    else n_pass++;
  endtask

  task automatic test_error();
    do_reset();
    for (int k = 0; k < 6; k++) drive(jcode[k], 1, 0);
    drive(8'b0101_0101, 1, 0);
    n_total++;
    if (err !== 1'b1 || locked !== 1'b0 || phase !== 4'd5 || obs !== exp_vec())
      $display("FAIL error_inject got=%h exp=%h", obs, exp_vec());
    else n_pass++;
    drive(jcode[7], 1, 0);
    n_total++;
    if (err !== 1'b1 || locked !== 1'b0) $display("FAIL error_sticky got=%h exp=%h", obs, exp_vec());
    else n_pass++;
    drive(jcode[6], 1, 1);
    n_total++;
    if (err !== 1'b0 || locked !== 1'b0 || obs !== exp_vec())
      $display("FAIL error_clear got=%h exp=%h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 4; k++) drive(jcode[k], 1, 0);
    for (int s = 0; s < 3; s++) begin
      drive(jcode[3], 1, 0);
      n_total++;
      if (locked !== 1'b1 || err !== 1'b0 || obs !== exp_vec())
        $display("FAIL stall%0d got=%h exp=%h", s, obs, exp_vec());
      else n_pass++;
    end
    drive(jcode[6], 1, 0);
    n_total++;
    if (err !== 1'b1 || locked !== 1'b0) $display("FAIL stall_jump got=%h exp=%h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_rollover();
    int idx, steps;
    logic [15:0] snap;
    do_reset();
    for (int k = 0; k < 4; k++) drive(jcode[k], 1, 0);
    idx = 3; steps = 0;
    while (m_cnt != 255 && steps < 5000) begin
      idx = (idx + 1) % 16;
      drive(jcode[idx], 1, 0);
      steps++;
      n_total++;
      if (obs !== exp_vec()) $display("FAIL roll_walk%0d got=%h exp=%h", steps, obs, exp_vec());
      else n_pass++;
    end
    n_total++;
    if (cycle_cnt !== 8'd255) $display("FAIL roll_255 got=%0d exp=255", cycle_cnt);
    else n_pass++;
    for (int s = 0; s < 16; s++) begin
      idx = (idx + 1) % 16;
      drive(jcode[idx], 1, 0);
    end
    n_total++;
    if (cycle_cnt !== 8'd0 || wrap !== 1'b1) $display("FAIL roll_zero got cnt=%0d wrap=%b exp cnt=0 wrap=1", cycle_cnt, wrap);
    else n_pass++;
    for (int s = 0; s < 3; s++) begin idx = (idx + 1) % 16; drive(jcode[idx], 1, 0); end
    snap = obs;
    for (int s = 0; s < 5; s++) begin
      drive(8'($urandom), 0, 1'($urandom));
      n_total++;
      if (obs !== snap || obs !== exp_vec()) $display("FAIL freeze%0d got=%h exp=%h", s, obs, snap);
      else n_pass++;
    end
    idx = (idx + 1) % 16;
    drive(jcode[idx], 1, 0);
    n_total++;
    if (locked !== 1'b1 || err !== 1'b0 || obs !== exp_vec()) $display("FAIL freeze_resume got=%h exp=%h", obs, exp_vec());
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 6; k++) drive(jcode[k], 1, 0);
    #3;
    rst = 0;
    model_reset();
    #1;
    n_total++;
    if (obs !== 16'h0000) $display("FAIL async_reset got=%h exp=0000", obs);
    else n_pass++;
`ifdef JOHNSON_TRACKER_ONEHOT_EN
    n_total++;
    if (phase_oh !== 16'h0001) $display("FAIL async_onehot got=%h exp=0001", phase_oh);
    else n_pass++;
`endif
    #10;
    rst = 1;
    for (int k = 7; k < 12; k++) begin
      drive(jcode[k], 1, 0);
      n_total++;
      if (obs !== exp_vec() || locked !== (k >= 7 + LR - 1))
        $display("FAIL reacquire%0d got=%h exp=%h", k, obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int idx, r;
    logic [7:0] q;
    do_reset();
    idx = 0;
    for (int s = 0; s < 800; s++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin idx = (idx + 1) % 16; q = jcode[idx]; end
      else if (r < 80) q = jcode[idx];
      else if (r < 86) begin idx = $urandom_range(0, 15); q = jcode[idx]; end
      else begin
        q = 8'($urandom);
        while (code_index(q) >= 0) q = 8'($urandom);
      end
      drive(q, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
      n_total++;
      if (obs !== exp_vec()) $display("FAIL random%0d q=%h got=%h exp=%h", s, q, obs, exp_vec());
      else n_pass++;
`ifdef JOHNSON_TRACKER_ONEHOT_EN
      n_total++;
      if (phase_oh !== m_oh) $display("FAIL random_oh%0d got=%h exp=%h", s, phase_oh, m_oh);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    jcode[0] = 8'h00;
    for (int k = 1; k < 16; k++) jcode[k] = {jcode[k-1][6:0], ~jcode[k-1][7]};
    test_reset();
    test_acquire();
    test_wrap();
    test_error();
    test_stall();
    test_rollover();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/johnson_phase_tracker.md
JOHNSON_PHASE_TRACKER -- requirements
Module: johnson_phase_tracker

Interface
REQ-001 SHALL have parameter LOCK_RUN, default 4, meaning consecutive in-sequence codes required to lock (legal range 2..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port en  input  1  sample enable; when 0, no state or output changes (pulses forced 0).
REQ-005 SHALL have port q_in  input  8  Johnson counter state from the upstream 8-bit counter.
REQ-006 SHALL have port err_clr  input  1  clears sticky error.
REQ-007 SHALL have port phase  output  4  decoded phase index 0..15.
REQ-008 SHALL have port phase_valid  output  1  last sampled code was legal.
REQ-009 SHALL have port locked  output  1  tracker in LOCKED state.
REQ-010 SHALL have port err  output  1  sticky sequence/code error.
REQ-011 SHALL have port cycle_cnt  output  8  completed Johnson cycles while locked.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse on each 15->0 transition while locked.

Function
REQ-013 Legal codes SHALL be exactly the 16 codes of q<={q[6:0],~q[7]}: contiguous ones from bit 0 (incl. 00000000, 11111111) or contiguous ones ending at bit 7.
REQ-014 Decode SHALL be: q_in==0 or q_in[0]==1 -> phase=popcount; else phase=16-popcount (00000001->1, 11111111->8, 11111110->9, 10000000->15).
REQ-015 All outputs SHALL be registered; 1-cycle latency from q_in sampled at edge N to outputs valid after edge N.
REQ-016 On illegal code: phase_valid=0, phase SHALL hold previous value.
REQ-017 States SHALL be UNLOCKED, ACQUIRE, LOCKED, ERROR.
REQ-018 UNLOCKED: legal code -> ACQUIRE, run=1, prev=phase; illegal -> stay.
REQ-019 ACQUIRE: phase==prev+1 mod 16 -> run+1, LOCKED when run reaches LOCK_RUN; phase==prev -> hold (stall); other legal -> run=1; illegal -> UNLOCKED.
REQ-020 LOCKED: prev+1 or prev (stall) -> stay; illegal or out-of-sequence -> ERROR, err=1 on same edge.
REQ-021 ERROR: err and state held until err_clr=1 -> UNLOCKED, err=0; code ignored that cycle.
REQ-022 err_clr SHALL take priority over a simultaneous error event in any state; in UNLOCKED/ACQUIRE/LOCKED it forces UNLOCKED.
REQ-023 cycle_cnt SHALL increment, wrap pulse 1 for one cycle, only when in LOCKED and phase advances 15->0; 255 wraps to 0.
REQ-024 Lock-achieving transition 15->0 SHALL NOT count a cycle.
REQ-025 en=0 SHALL freeze all state including run and prev; en applies also to err_clr.

Reset
REQ-026 rst=0 SHALL immediately force state UNLOCKED, run=0, prev=0, phase=0, phase_valid=0, locked=0, err=0, cycle_cnt=0, wrap=0, regardless of clk.
REQ-027 Reset mid-LOCKED SHALL lose lock; after release, full LOCK_RUN reacquisition required.

Configuration
REQ-028 Macro JOHNSON_TRACKER_ONEHOT_EN defined SHALL add output phase_oh (16 bits), registered one-hot of phase, reset 16'h0001, all-zero while phase_valid=0.
REQ-029 Macro undefined SHALL omit phase_oh port and logic; all other behaviour identical.

Verification
REQ-030 Reset then q_in stepping 00..01..03..07..0F each edge, en=1 -> phase 0,1,2,3,4; locked=1 after 4th in-sequence code (LOCK_RUN=4).
REQ-031 Locked, run full cycle 15->0 twice -> cycle_cnt=2, wrap high exactly two single cycles.
REQ-032 Locked at phase 5, inject q_in=8'b01010101 -> err=1, locked=0, phase holds 5; err_clr=1 -> err=0, UNLOCKED.
REQ-033 Locked at phase 3, repeat code 00000111 three edges -> no error, locked stays 1; then phase 6 -> err=1.
REQ-034 Force cycle_cnt to 255 via 255 cycles then one more cycle -> cycle_cnt=0, wrap=1; en=0 for 5 edges mid-sequence -> outputs frozen.
REQ-035 Assert rst=0 between clk edges while locked -> all outputs 0 immediately; with ONEHOT_EN phase_oh=16'h0001.
